// File: rtl/stopwatch_core_if.sv
// Button inputs and display-side outputs of the stopwatch timekeeping stage.
// The core takes the slave side; the driver of the buttons takes the master side.
interface stopwatch_core_if;
    logic       btn_ss;
    logic       btn_lap;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [2:0] min_tens;
    logic       running;
    logic       lap_hold;
    logic       tick;

    modport master (
        output btn_ss, btn_lap,
        input  sec_ones, sec_tens, min_ones, min_tens,
        input  running, lap_hold, tick
    );

    modport slave (
        input  btn_ss, btn_lap,
        output sec_ones, sec_tens, min_ones, min_tens,
        output running, lap_hold, tick
    );
endinterface

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping: button debounce, start/stop/lap/clear FSM,
// gated tick prescaler and an mm:ss BCD count with a lap latch.
module stopwatch_core #(
    parameter int TICK_DIV   = 500,
    parameter int DEB_CYCLES = 16
) (
    input  logic           clock,
    input  logic           reset,
    stopwatch_core_if.slave sw
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAP,
        S_PAUSE
    } state_t;

    logic [1:0]    w_raw;
    logic [1:0]    r_s1;
    logic [1:0]    r_s2;
    logic [1:0]    r_lvl;
    logic [1:0]    r_lvl_d;
    logic [DW-1:0] r_dcnt [2];
    logic [1:0]    w_press;
    logic          w_ss;
    logic          w_lap;

    state_t        r_state;
    state_t        w_next;
    logic          w_capture;
    logic          w_clear;
    logic          w_running;
    logic          w_tick;

    logic [PW-1:0] r_pre;
    logic [3:0]    r_so;
    logic [2:0]    r_st;
    logic [3:0]    r_mo;
    logic [2:0]    r_mt;
    logic [3:0]    r_lap_so;
    logic [2:0]    r_lap_st;
    logic [3:0]    r_lap_mo;
    logic [2:0]    r_lap_mt;

    assign w_raw = {sw.btn_lap, sw.btn_ss};

    // Bit 0 is start/stop, bit 1 is lap/clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_lvl   <= '0;
            r_lvl_d <= '0;
            for (int b = 0; b < 2; b++) r_dcnt[b] <= '0;
        end else begin
            r_s1    <= w_raw;
            r_s2    <= r_s1;
            r_lvl_d <= r_lvl;
            for (int b = 0; b < 2; b++) begin
                if (r_s2[b] != r_lvl[b]) begin
                    if (r_dcnt[b] == DW'(DEB_CYCLES - 1)) begin
                        r_lvl[b]  <= r_s2[b];
                        r_dcnt[b] <= '0;
                    end else begin
                        r_dcnt[b] <= r_dcnt[b] + 1'b1;
                    end
                end else begin
                    r_dcnt[b] <= '0;
                end
            end
        end
    end

    assign w_press = r_lvl & ~r_lvl_d;
    assign w_ss    = w_press[0];
    assign w_lap   = w_press[1] & ~w_press[0];

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_clear   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_ss) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_ss) begin
                    w_next = S_PAUSE;
                end else if (w_lap) begin
                    w_next    = S_LAP;
                    w_capture = 1'b1;
                end
            end
            S_LAP: begin
                if (w_ss)       w_next = S_PAUSE;
                else if (w_lap) w_next = S_RUN;
            end
            S_PAUSE: begin
                if (w_ss) begin
                    w_next = S_RUN;
                end else if (w_lap) begin
                    w_next  = S_IDLE;
                    w_clear = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_running = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick    = w_running && (r_pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset || w_clear) r_pre <= '0;
        else if (w_running)   r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset || w_clear) begin
            r_so <= '0;
            r_st <= '0;
            r_mo <= '0;
            r_mt <= '0;
        end else if (w_tick) begin
            if (r_so != 4'd9) begin
                r_so <= r_so + 1'b1;
            end else begin
                r_so <= '0;
                if (r_st != 3'd5) begin
                    r_st <= r_st + 1'b1;
                end else begin
                    r_st <= '0;
                    if (r_mo != 4'd9) begin
                        r_mo <= r_mo + 1'b1;
                    end else begin
                        r_mo <= '0;
                        r_mt <= (r_mt == 3'd5) ? 3'd0 : r_mt + 1'b1;
                    end
                end
            end
        end
    end

    // Latch holds the pre-increment count when a tick coincides.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lap_so <= '0;
            r_lap_st <= '0;
            r_lap_mo <= '0;
            r_lap_mt <= '0;
        end else if (w_capture) begin
            r_lap_so <= r_so;
            r_lap_st <= r_st;
            r_lap_mo <= r_mo;
            r_lap_mt <= r_mt;
        end
    end

    assign sw.lap_hold = (r_state == S_LAP);
    assign sw.running  = w_running;
    assign sw.tick     = w_tick;
    assign sw.sec_ones = sw.lap_hold ? r_lap_so : r_so;
    assign sw.sec_tens = sw.lap_hold ? r_lap_st : r_st;
    assign sw.min_ones = sw.lap_hold ? r_lap_mo : r_mo;
    assign sw.min_tens = sw.lap_hold ? r_lap_mt : r_mt;
endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed and random button sequences checked
// every cycle against a seconds-based reference model.
module tb_stopwatch_core;
    localparam int TD  = 5;
    localparam int DEB = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_LAP   = 2;
    localparam int M_PAUSE = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    stopwatch_core_if bus ();

    stopwatch_core #(
        .TICK_DIV   (TD),
        .DEB_CYCLES (DEB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sw    (bus.slave)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_s1  [2];
    int m_s2  [2];
    int m_lvl [2];
    int m_lvd [2];
    int m_cnt [2];
    int m_state = M_IDLE;
    int m_pre   = 0;
    int m_secs  = 0;
    int m_lap   = 0;

    function automatic logic [13:0] dig(input int d);
        logic [3:0] so;
        logic [2:0] st;
        logic [3:0] mo;
        logic [2:0] mt;
        so = 4'(d % 10);
        st = 3'((d / 10) % 6);
        mo = 4'((d / 60) % 10);
        mt = 3'(d / 600);
        return {so, st, mo, mt};
    endfunction

    function automatic logic [13:0] dut_dig();
        return {bus.sec_ones, bus.sec_tens, bus.min_ones, bus.min_tens};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic ss, input logic lap, input logic rst);
        int ps, pl, run, tk, nst, raw [2];
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0;
                m_lvd[b] = 0; m_cnt[b] = 0;
            end
            m_state = M_IDLE; m_pre = 0; m_secs = 0; m_lap = 0;
            return;
        end
        ps  = (m_lvl[0] == 1 && m_lvd[0] == 0) ? 1 : 0;
        pl  = (m_lvl[1] == 1 && m_lvd[1] == 0 && ps == 0) ? 1 : 0;
        run = (m_state == M_RUN || m_state == M_LAP) ? 1 : 0;
        tk  = (run == 1 && m_pre == TD - 1) ? 1 : 0;
        nst = m_state;
        case (m_state)
            M_IDLE:  if (ps == 1) nst = M_RUN;
            M_RUN:   if (ps == 1) nst = M_PAUSE; else if (pl == 1) nst = M_LAP;
            M_LAP:   if (ps == 1) nst = M_PAUSE; else if (pl == 1) nst = M_RUN;
            default: if (ps == 1) nst = M_RUN; else if (pl == 1) nst = M_IDLE;
        endcase
        if (m_state == M_RUN && pl == 1) m_lap = m_secs;
        if (m_state == M_PAUSE && pl == 1) begin
            m_pre = 0;
            m_secs = 0;
        end else begin
            if (run == 1) m_pre = (tk == 1) ? 0 : m_pre + 1;
            if (tk == 1) m_secs = (m_secs + 1) % 3600;
        end
        m_state = nst;
        raw[0] = int'(ss);
        raw[1] = int'(lap);
        for (int b = 0; b < 2; b++) begin
            m_lvd[b] = m_lvl[b];
            if (m_s2[b] != m_lvl[b]) begin
                m_cnt[b]++;
                if (m_cnt[b] == DEB) begin
                    m_lvl[b] = m_s2[b];
                    m_cnt[b] = 0;
                end
            end else begin
                m_cnt[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
    endtask

    task automatic check_all(input string tag);
        logic [16:0] obs, exp;
        logic run, hold, tk;
        int d;
        run  = (m_state == M_RUN || m_state == M_LAP);
        hold = (m_state == M_LAP);
        tk   = run && (m_pre == TD - 1);
        d    = hold ? m_lap : m_secs;
        exp  = {dig(d), run, hold, tk};
        obs  = {dut_dig(), bus.running, bus.lap_hold, bus.tick};
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ss, input logic lap, input logic rst);
        bus.btn_ss  = ss;
        bus.btn_lap = lap;
        reset       = rst;
        @(posedge clock);
        model_edge(ss, lap, rst);
        #1;
        check_all("cycle");
        @(negedge clock);
    endtask

    task automatic press(input logic ss, input logic lap, input int hold, input int after);
        repeat (hold)  step(ss, lap, 1'b0);
        repeat (after) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int first, entries, prev, nt, k;
        logic rs, rl;
        bus.btn_ss  = 1'b0;
        bus.btn_lap = 1'b0;
        @(negedge clock);

        step(1'b0, 1'b0, 1'b1);
        chk("reset_zero", int'({dut_dig(), bus.running, bus.lap_hold, bus.tick}), 0);
        step(1'b0, 1'b0, 1'b1);

        press(1'b1, 1'b0, 3, 10);
        chk("deb_short", int'(bus.running), 0);

        first = -1; entries = 0; prev = 0;
        for (int i = 0; i < 14; i++) begin
            step((i < 8) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (bus.running && first < 0) first = i + 1;
            if (bus.running && prev == 0) entries++;
            prev = int'(bus.running);
        end
        chk("deb_latency", first, 7);
        chk("one_entry", entries, 1);

        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 0, 10);
        chk("bounce", int'(bus.running), 1);

        nt = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0, 1'b0);
            nt += int'(bus.tick);
        end
        chk("ticks50", nt, 10);

        press(1'b0, 1'b1, 6, 4);
        chk("lap_hold", int'(bus.lap_hold), 1);
        press(1'b0, 1'b0, 0, 40);
        chk("lap_frozen", int'(dut_dig()), int'(dig(m_lap)));
        press(1'b0, 1'b1, 6, 4);
        chk("lap_release", int'(bus.lap_hold), 0);
        chk("live_again", int'(dut_dig()), int'(dig(m_secs)));

        press(1'b1, 1'b0, 6, 4);
        nt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            nt += int'(bus.tick);
        end
        chk("pause_notick", nt, 0);
        chk("pause_run", int'(bus.running), 0);
        press(1'b1, 1'b0, 6, 15);
        chk("resume", int'(bus.running), 1);
        press(1'b1, 1'b0, 6, 4);
        press(1'b0, 1'b1, 6, 4);
        chk("clear", int'(dut_dig()), 0);
        press(1'b0, 1'b1, 6, 10);
        chk("idle_lap", int'(bus.running), 0);

        press(1'b1, 1'b0, 6, 20);
        press(1'b1, 1'b1, 6, 4);
        chk("prio_run", int'(bus.running), 0);
        chk("prio_hold", int'(bus.lap_hold), 0);

        press(1'b1, 1'b0, 6, 12);
        press(1'b0, 1'b1, 6, 4);
        chk("pre_rst_lap", int'(bus.lap_hold), 1);
        press(1'b1, 1'b0, 3, 0);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_midlap", int'({dut_dig(), bus.running, bus.lap_hold, bus.tick}), 0);
        press(1'b0, 1'b0, 0, 12);
        chk("rst_discard", int'(bus.running), 0);

        for (int i = 0; i < 60; i++) begin
            rs = 1'($urandom % 2);
            rl = 1'($urandom % 2);
            k  = int'($urandom_range(1, 10));
            repeat (k) step(rs, rl, 1'b0);
        end

        step(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 6, 4);
        k = 0;
        while (m_secs != 3599 && k < 20000) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        chk("reach_5959", int'(dut_dig()), int'(dig(3599)));
        k = 0;
        while (m_secs != 0 && k < 10) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        chk("wrap_zero", int'(dut_dig()), 0);
        chk("wrap_run", int'(bus.running), 1);
        nt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            nt += int'(bus.tick);
        end
        chk("tick_after_wrap", nt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Upstream timekeeping stage for the 4-digit seven-segment stopwatch display.
- Debounces two push buttons and runs a start/stop/lap/clear state machine.
- Generates a gated one-count tick and keeps an mm:ss BCD count.
- Presents live or lap-frozen digits to the display scanner/decoder stage, with digit widths matching that stage (ones 4 bits, tens 3 bits).

Parameters:
- TICK_DIV, 500: clock cycles per count tick; the prescaler wraps at TICK_DIV-1.
- DEB_CYCLES, 16: consecutive stable samples needed before a debounced button level changes.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_ss  in  1  raw start/stop button, active-high, asynchronous to clock.
- btn_lap  in  1  raw lap/clear button, active-high, asynchronous to clock.
- sec_ones  out  4  displayed seconds units, 0-9.
- sec_tens  out  3  displayed seconds tens, 0-5.
- min_ones  out  4  displayed minutes units, 0-9.
- min_tens  out  3  displayed minutes tens, 0-5.
- running  out  1  high in RUN or LAP.
- lap_hold  out  1  high in LAP; display is frozen.
- tick  out  1  one-cycle pulse when the prescaler wraps.

Behaviour:
- Interface: one clock, named clock. Reset is named reset and is synchronous, active-high; it is sampled only on the rising edge of clock.
- Reset:
  - State goes to IDLE.
  - Debounced levels, press pulses, prescaler, count and lap latch all go to 0.
  - All outputs are 0 on the first edge with reset high.
  - Reset overrides everything, including mid-RUN, mid-LAP and in-flight debounce.
- Debounce, per button:
  - Two-flop synchronizer, then a stability counter.
  - The debounced level takes the new raw level once the raw level has differed from it for DEB_CYCLES consecutive samples.
  - Any mismatch-free sample clears the counter.
  - A rising edge of the debounced level produces a one-cycle press pulse. Releases produce nothing.
- Press priority: if both press pulses occur in the same cycle, ss is acted on and lap is dropped.
- FSM transitions (registered; takes effect on the edge that samples the press):
  - IDLE: ss -> RUN. lap is ignored.
  - RUN: ss -> PAUSE. lap -> LAP; the lap latch captures the current count (the pre-increment value if a tick coincides).
  - LAP: lap -> RUN, and the display returns to live. ss -> PAUSE, and the display returns to live showing the stopped count.
  - PAUSE: ss -> RUN. lap -> IDLE; count and prescaler clear to 0.
- Prescaler:
  - Advances only in RUN and LAP; holds its value in PAUSE; is 0 in IDLE.
  - At value TICK_DIV-1 it wraps to 0 and asserts tick for that cycle.
  - Resuming from PAUSE continues from the held prescaler value; there is no restart of the partial second.
- Count, BCD cascade:
  - On tick, sec_ones increments. 9 -> 0 carries into sec_tens; sec_tens 5 -> 0 carries into min_ones; min_ones 9 -> 0 carries into min_tens; min_tens 5 -> 0.
  - 59:59 + tick = 00:00; running is unaffected.
  - The count is updated on the edge after the tick cycle.
  - Digits never leave their legal ranges.
- Display mux (combinational): outputs = lap latch when in LAP, else the live count registers.
- tick is combinational from the prescaler compare, gated by running.

Test Plan:
- Debounce (DEB_CYCLES=4, TICK_DIV=5): after reset, btn_ss high for 3 clocks -> running stays 0. btn_ss held high for 8 clocks -> running=1 a fixed 2+4 (+1 register) cycles after the rising edge, with exactly one RUN entry. Bounce pattern 1,0,1,1 -> no press.
- Counting: from RUN, count 50 clocks -> tick pulses exactly every 5 clocks, 10 pulses total; display 00:10 (sec_ones=0, sec_tens=1, min=0).
- Wrap: preload by running to 59:58, apply 2 ticks -> 59:59 then 00:00; running=1, tick continues.
- Lap: RUN at 00:07, press lap -> lap_hold=1, display frozen at 00:07 while the internal count advances. Press lap again when the internal count is 00:12 -> lap_hold=0, display 00:12 the next cycle.
- Pause/clear: in RUN at 00:03 with prescaler=2, press ss -> PAUSE; hold 20 clocks -> display 00:03, no tick. Press ss -> the first tick arrives 3 clocks later. Press ss, then lap -> IDLE, display 00:00, prescaler 0. Lap in IDLE -> no change.
- Priority/reset: in RUN, btn_ss and btn_lap debounced in the same cycle -> PAUSE, lap_hold=0. Reset high for 1 clock mid-LAP -> all outputs 0 and IDLE on that edge; a press already mid-debounce is discarded.
